// File: rtl/uart_pkg.sv
// Shared UART character constants and line-assembler state encodings.
// No logic; latency and backpressure are not applicable.
package uart_pkg;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_BS = 8'h08;

    typedef enum logic {
        WST_RX  = 1'b0,
        WST_OVF = 1'b1
    } wst_t;

    typedef enum logic {
        OST_EMPTY = 1'b0,
        OST_FULL  = 1'b1
    } ost_t;

endpackage

// File: rtl/uart_rise_det.sv
// Rising-edge detector on the byte-receiver data-enable level; pulse is combinational
// from the registered previous level (0-cycle latency), no backpressure.
module uart_rise_det (
    input  logic CLK,
    input  logic RST,
    input  logic iCLR,
    input  logic iDE,
    output logic oRISE
);

    logic de_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            de_q <= 1'b0;
        end else if (iCLR) begin
            de_q <= 1'b0;
        end else begin
            de_q <= iDE;
        end
    end

    assign oRISE = iDE & ~de_q;

endmodule

// File: rtl/uart_line_assembler.sv
// Assembles UART characters into lines (backspace, CR drop, overflow) and commits them to a
// held output; 1-cycle commit latency; a line arriving while the output is unacked is dropped.
module uart_line_assembler
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] TERM_CHAR  = CHAR_LF,
    parameter logic [DATA_WIDTH-1:0] BS_CHAR    = CHAR_BS,
    parameter logic [DATA_WIDTH-1:0] CR_CHAR    = CHAR_CR,
    parameter bit                    DROP_CR    = 1'b1,
    localparam int                   LEN_W      = $clog2(DEPTH + 1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        iCLR,
    input  logic                        iDE,
    input  logic [DATA_WIDTH-1:0]       iDATA,
    output logic                        oLINE_VALID,
    input  logic                        iLINE_ACK,
    output logic [DATA_WIDTH*DEPTH-1:0] oLINE_DATA,
    output logic [LEN_W-1:0]            oLINE_LEN,
    output logic                        oLINE_OVF,
    output logic                        oDROP
);

    localparam logic [LEN_W-1:0] DEPTH_C = LEN_W'(DEPTH);

    logic                                 ev;
    wst_t                                 wst_q, wst_d;
    ost_t                                 ost_q, ost_d;
    logic [LEN_W-1:0]                     wcnt_q, wcnt_d;
    logic                                 wovf_q, wovf_d;
    logic                                 buf_we, commit, drop_set;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     wbuf_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     masked;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     line_q;

    uart_rise_det u_rise (
        .CLK   (CLK),
        .RST   (RST),
        .iCLR  (iCLR),
        .iDE   (iDE),
        .oRISE (ev)
    );

    always_comb begin
        wst_d    = wst_q;
        ost_d    = ost_q;
        wcnt_d   = wcnt_q;
        wovf_d   = wovf_q;
        buf_we   = 1'b0;
        commit   = 1'b0;
        drop_set = 1'b0;
        if (ev) begin
            if (iDATA == TERM_CHAR) begin
                wst_d  = WST_RX;
                wcnt_d = '0;
                wovf_d = 1'b0;
                if (ost_q == OST_EMPTY || iLINE_ACK) begin
                    commit = 1'b1;
                end else begin
                    drop_set = 1'b1;
                end
            end else if (wst_q == WST_RX) begin
                if (iDATA == BS_CHAR) begin
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - LEN_W'(1);
                    end
                end else if (!(DROP_CR && iDATA == CR_CHAR)) begin
                    if (wcnt_q == DEPTH_C) begin
                        wovf_d = 1'b1;
                        wst_d  = WST_OVF;
                    end else begin
                        buf_we = 1'b1;
                        wcnt_d = wcnt_q + LEN_W'(1);
                    end
                end
            end
        end
        // A commit in the same cycle as an ack keeps the output full with the new line
        if (commit) begin
            ost_d = OST_FULL;
        end else if (ost_q == OST_FULL && iLINE_ACK) begin
            ost_d = OST_EMPTY;
        end
    end

    always_comb begin
        masked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (LEN_W'(i) < wcnt_q) begin
                masked[i] = wbuf_q[i];
            end
        end
    end

    // Buffer contents beyond wcnt are never observed, so the array needs no reset
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (buf_we && wcnt_q == LEN_W'(i)) begin
                wbuf_q[i] <= iDATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wst_q     <= WST_RX;
            ost_q     <= OST_EMPTY;
            wcnt_q    <= '0;
            wovf_q    <= 1'b0;
            line_q    <= '0;
            oLINE_LEN <= '0;
            oLINE_OVF <= 1'b0;
            oDROP     <= 1'b0;
        end else if (iCLR) begin
            wst_q     <= WST_RX;
            ost_q     <= OST_EMPTY;
            wcnt_q    <= '0;
            wovf_q    <= 1'b0;
            line_q    <= '0;
            oLINE_LEN <= '0;
            oLINE_OVF <= 1'b0;
            oDROP     <= 1'b0;
        end else begin
            wst_q  <= wst_d;
            ost_q  <= ost_d;
            wcnt_q <= wcnt_d;
            wovf_q <= wovf_d;
            oDROP  <= oDROP | drop_set;
            if (commit) begin
                line_q    <= masked;
                oLINE_LEN <= wcnt_q;
                oLINE_OVF <= wovf_q;
            end
        end
    end

    assign oLINE_VALID = (ost_q == OST_FULL);
    assign oLINE_DATA  = line_q;

endmodule
